// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the shared RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    output d_gnt, d_rvalid, d_rdata, d_stall,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    input  d_gnt, d_rvalid, d_rdata, d_stall,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: data port has priority, fetch is forced through after
// STARVE_MAX consecutive denied cycles. Read data returns one cycle after grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_if_vld_p1;
  logic              r_d_vld_p1;

  logic              w_starved;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_rdata;

  // Stage p0: combinational arbitration and RAM drive
  always_comb begin
    w_starved  = (r_starve_cnt == CNT_MAX);
    w_if_gnt   = ~reset & bus.if_req & (~bus.d_req | w_starved);
    w_d_gnt    = ~reset & bus.d_req & ~w_if_gnt;
    w_ram_addr = w_if_gnt ? bus.if_addr : bus.d_addr;
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_stall  = bus.if_req & ~w_if_gnt;
  assign bus.d_stall   = bus.d_req & ~w_d_gnt;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_d_gnt & bus.d_we;
  assign bus.ram_wdata = bus.d_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (~bus.if_req | w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Stage p1: read response, one cycle after grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_vld_p1 <= 1'b0;
      r_d_vld_p1  <= 1'b0;
    end else begin
      r_if_vld_p1 <= w_if_gnt;
      r_d_vld_p1  <= w_d_gnt & ~bus.d_we;
    end
  end

  // Gating with reset drops a response already registered when reset arrives.
  assign w_rdata       = bus.ram_rdata;
  assign bus.if_rvalid = r_if_vld_p1 & ~reset;
  assign bus.d_rvalid  = r_d_vld_p1 & ~reset;
  assign bus.if_rdata  = w_rdata;
  assign bus.d_rdata   = w_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc();
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic ir, input logic [ADDR_W-1:0] ia,
                       input logic dr, input logic dw,
                       input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
    bus.if_req = ir; bus.if_addr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
  endtask

  initial begin
    logic exp_if, prev_if;
    n_checks = 0; n_errors = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    reset = 1'b1;
    drive(1'b1, 9'h005, 1'b1, 1'b1, 9'h030, 16'hFFFF);
    cyc();
    preload(9'h005, 16'hC00A);
    preload(9'h020, 16'hBEEF);
    mid();
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_cnt", dut.r_starve_cnt, 0);
    cyc();
    reset = 1'b0;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000);
    cyc();

    // 1: lone fetch
    drive(1'b1, 9'h005, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t1_if_gnt", bus.if_gnt, 1);
    chk("t1_d_gnt", bus.d_gnt, 0);
    chk("t1_if_stall", bus.if_stall, 0);
    chk("t1_ram_addr", bus.ram_addr, 9'h005);
    cyc();
    drive(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t1_if_rvalid", bus.if_rvalid, 1);
    chk("t1_if_rdata", bus.if_rdata, 16'hC00A);
    chk("t1_d_rvalid", bus.d_rvalid, 0);

    // 2: contention, data read wins
    cyc();
    drive(1'b1, 9'h010, 1'b1, 1'b0, 9'h020, 16'h0000);
    mid();
    chk("t2_d_gnt", bus.d_gnt, 1);
    chk("t2_if_gnt", bus.if_gnt, 0);
    chk("t2_if_stall", bus.if_stall, 1);
    chk("t2_d_stall", bus.d_stall, 0);
    chk("t2_ram_addr", bus.ram_addr, 9'h020);
    cyc();
    drive(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t2_d_rvalid", bus.d_rvalid, 1);
    chk("t2_d_rdata", bus.d_rdata, 16'hBEEF);
    chk("t2_if_rvalid", bus.if_rvalid, 0);

    // 3: store then fetch of the same word
    cyc();
    drive(1'b0, 9'h000, 1'b1, 1'b1, 9'h030, 16'h1234);
    mid();
    chk("t3_d_gnt", bus.d_gnt, 1);
    chk("t3_ram_we", bus.ram_we, 1);
    chk("t3_ram_wdata", bus.ram_wdata, 16'h1234);
    chk("t3_ram_addr", bus.ram_addr, 9'h030);
    cyc();
    drive(1'b1, 9'h030, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t3_ram_we_off", bus.ram_we, 0);
    chk("t3_if_gnt", bus.if_gnt, 1);
    chk("t3_d_rvalid", bus.d_rvalid, 0);
    cyc();
    drive(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t3_if_rvalid", bus.if_rvalid, 1);
    chk("t3_if_rdata", bus.if_rdata, 16'h1234);

    // 4: 12 cycles of continuous contention; fetch wins on cycles 5 and 10
    cyc();
    drive(1'b1, 9'h005, 1'b1, 1'b0, 9'h020, 16'h0000);
    prev_if = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_if = (i == 4) || (i == 9);
      mid();
      chk($sformatf("t4_if_gnt_c%0d", i + 1), bus.if_gnt, exp_if);
      chk($sformatf("t4_d_gnt_c%0d", i + 1), bus.d_gnt, !exp_if);
      if (i > 0) begin
        chk($sformatf("t4_if_rv_c%0d", i + 1), bus.if_rvalid, prev_if);
        chk($sformatf("t4_d_rv_c%0d", i + 1), bus.d_rvalid, !prev_if);
        chk($sformatf("t4_rdata_c%0d", i + 1), bus.if_rdata, prev_if ? 16'hC00A : 16'hBEEF);
      end
      if (i == 3) chk("t4_cnt_pre", dut.r_starve_cnt, 3);
      if (i == 4) chk("t4_cnt_max", dut.r_starve_cnt, 4);
      if (i == 5) chk("t4_cnt_clr", dut.r_starve_cnt, 0);
      prev_if = exp_if;
      cyc();
    end

    // 5: read granted, then reset with a pending write request
    drive(1'b0, 9'h000, 1'b1, 1'b0, 9'h020, 16'h0000);
    mid();
    chk("t5_d_gnt", bus.d_gnt, 1);
    cyc();
    reset = 1'b1;
    drive(1'b1, 9'h005, 1'b1, 1'b1, 9'h020, 16'h0BAD);
    mid();
    chk("t5_d_rvalid_rst", bus.d_rvalid, 0);
    chk("t5_ram_we_rst0", bus.ram_we, 0);
    chk("t5_gnt_rst0", {bus.if_gnt, bus.d_gnt}, 0);
    cyc();
    mid();
    chk("t5_ram_we_rst1", bus.ram_we, 0);
    chk("t5_if_rvalid_rst", bus.if_rvalid, 0);
    chk("t5_cnt_rst", dut.r_starve_cnt, 0);
    cyc();
    reset = 1'b0;
    drive(1'b0, 9'h000, 1'b1, 1'b0, 9'h020, 16'h0000);
    mid();
    chk("t5_rvalid_post", {bus.if_rvalid, bus.d_rvalid}, 0);
    cyc();
    drive(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t5_no_write", bus.d_rdata, 16'hBEEF);

    // 6: starved fetch beats a store; store completes next cycle
    cyc();
    drive(1'b1, 9'h005, 1'b1, 1'b0, 9'h020, 16'h0000);
    for (int i = 0; i < 4; i++) cyc();
    drive(1'b1, 9'h005, 1'b1, 1'b1, 9'h040, 16'h5A5A);
    mid();
    chk("t6_cnt", dut.r_starve_cnt, 4);
    chk("t6_if_gnt", bus.if_gnt, 1);
    chk("t6_ram_we", bus.ram_we, 0);
    chk("t6_d_stall", bus.d_stall, 1);
    cyc();
    drive(1'b0, 9'h000, 1'b1, 1'b1, 9'h040, 16'h5A5A);
    mid();
    chk("t6_d_gnt", bus.d_gnt, 1);
    chk("t6_ram_we_on", bus.ram_we, 1);
    chk("t6_ram_addr", bus.ram_addr, 9'h040);
    chk("t6_if_rdata", bus.if_rdata, 16'hC00A);
    cyc();
    drive(1'b1, 9'h040, 1'b0, 1'b0, 9'h000, 16'h0000);
    cyc();
    drive(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000);
    mid();
    chk("t6_readback_vld", bus.if_rvalid, 1);
    chk("t6_readback", bus.if_rdata, 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
